// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyzer capture sequencer.
package la_pkg;

    // Encoding is visible on state_o, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PREFILL = 3'd1,
        ST_WAIT    = 3'd2,
        ST_POST    = 3'd3,
        ST_READOUT = 3'd4
    } la_state_t;

    localparam int LA_DATA_W = 16;
    localparam int LA_DEPTH  = 16;

    // Pointer width for a ring of the given depth.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Circular sample buffer: one synchronous write port, one combinational read port.
module la_sample_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Sample storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture sequencer: arm, pre-fill, wait for masked trigger, post-capture, stream out.
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int DATA_W   = LA_DATA_W,
    parameter int DEPTH    = LA_DEPTH,
    parameter int PRE_TRIG = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] probe,
    input  logic [DATA_W-1:0] trig_pattern,
    input  logic [DATA_W-1:0] trig_mask,
    output logic [2:0]        state_o,
    output logic              triggered,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);
    localparam logic [PTR_W-1:0] PRE_P    = PTR_W'(PRE_TRIG);
    localparam logic [PTR_W-1:0] PRE_LAST = PTR_W'((PRE_TRIG == 0) ? 0 : PRE_TRIG - 1);
    localparam logic [PTR_W-1:0] POST_N   = PTR_W'(DEPTH - PRE_TRIG - 1);
    localparam logic [PTR_W-1:0] LAST_W   = PTR_W'(DEPTH - 1);

    la_state_t         state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  trig_ptr_q;
    logic [PTR_W-1:0]  cnt_q;
    logic              triggered_q;
    logic              done_q;
    logic              out_valid_q;

    logic              match;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Masked compare; a zero mask matches every cycle.
    assign match = (((probe ^ trig_pattern) & trig_mask) == '0);

    // The buffer is only written while a capture is filling it, never during readout.
    assign ram_we = !abort &&
                    ((state_q == ST_WAIT) || (state_q == ST_POST) ||
                     ((state_q == ST_PREFILL) && (PRE_TRIG != 0)));

    la_sample_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (probe),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    // Capture FSM; cnt_q counts pre-fill writes, then remaining post writes, then readout words.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            cnt_q       <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q  <= ST_PREFILL;
                        wr_ptr_q <= '0;
                        cnt_q    <= '0;
                    end
                end
                ST_PREFILL: begin
                    if (PRE_TRIG == 0) begin
                        state_q <= ST_WAIT;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + ONE;
                        cnt_q    <= cnt_q + ONE;
                        if (cnt_q == PRE_LAST) begin
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    if (match) begin
                        trig_ptr_q  <= wr_ptr_q;
                        triggered_q <= 1'b1;
                        if (POST_N == '0) begin
                            state_q     <= ST_READOUT;
                            rd_ptr_q    <= wr_ptr_q - PRE_P;
                            cnt_q       <= '0;
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_POST;
                            cnt_q   <= POST_N;
                        end
                    end
                end
                ST_POST: begin
                    wr_ptr_q <= wr_ptr_q + ONE;
                    cnt_q    <= cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_q     <= ST_READOUT;
                        rd_ptr_q    <= trig_ptr_q - PRE_P;
                        cnt_q       <= '0;
                        done_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_READOUT: begin
                    if (out_ready) begin
                        rd_ptr_q <= rd_ptr_q + ONE;
                        cnt_q    <= cnt_q + ONE;
                        if (cnt_q == LAST_W) begin
                            state_q     <= ST_IDLE;
                            cnt_q       <= '0;
                            triggered_q <= 1'b0;
                            done_q      <= 1'b0;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o   = state_q;
    assign triggered = triggered_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? ram_rdata : '0;
    assign out_last  = out_valid_q && (cnt_q == LAST_W);

endmodule
